// File: rtl/dmem_read_sequencer.sv
// dmem_read_sequencer
// Sequences row-wise reads of the binary-MLP data memory (NUM_ROWS rows of
// ROW_LEN words). A run is started with a row window, the block drives read
// addresses, absorbs the memory's registered read latency and streams the
// returned words out through a small FIFO.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               one-cycle run request, sampled only in IDLE
//   row_base/row_count  first row and number of rows of the run
//   abort               synchronous flush of a run in progress
//   busy/done/err       run status; done and err are one-cycle pulses
//   mem_addr/mem_data   registered read address out, read data back
//   out_*               streaming output with row/frame tags
//   dbg_state           current FSM state (IDLE=0, RUN=1, DRAIN=2)
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid is high, it and the head word
// (out_data/out_last/out_frame_last/out_row) stay stable until that transfer.
module dmem_read_sequencer #(
  parameter int DATA_W     = 9,
  parameter int ADDR_W     = 7,
  parameter int ROW_LEN    = 16,
  parameter int NUM_ROWS   = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        row_base,
  input  logic [2:0]        row_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_frame_last,
  output logic [2:0]        out_row,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int COL_W = $clog2(ROW_LEN);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // FIFO entry: {row[2:0], last, frame_last, data}
  localparam int ENT_W = DATA_W + 5;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [2:0]        last_row_q, last_row_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Two-stage tag pipeline that runs alongside the memory read latency.
  logic              p1_v_q, p1_v_d, p1_last_q, p1_last_d, p1_flast_q, p1_flast_d;
  logic [2:0]        p1_row_q, p1_row_d;
  logic              p2_v_q, p2_v_d, p2_last_q, p2_last_d, p2_flast_q, p2_flast_d;
  logic [2:0]        p2_row_q, p2_row_d;

  logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic              flush, push, pop, issue_ok, col_last, head_valid;
  logic [3:0]        start_sum;
  logic [ENT_W-1:0]  head;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    row_d      = row_q;
    col_d      = col_q;
    last_row_d = last_row_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    p1_v_d     = 1'b0;
    p1_last_d  = p1_last_q;
    p1_flast_d = p1_flast_q;
    p1_row_d   = p1_row_q;
    p2_v_d     = p1_v_q;
    p2_last_d  = p1_last_q;
    p2_flast_d = p1_flast_q;
    p2_row_d   = p1_row_q;

    flush      = abort && (state_q != S_IDLE);
    start_sum  = {1'b0, row_base} + {1'b0, row_count};
    col_last   = (col_q == COL_W'(ROW_LEN - 1));
    // Words already buffered plus reads still in flight must fit in the FIFO,
    // so issue stalls rather than letting a returning word overflow it.
    issue_ok   = (int'(fifo_cnt_q) + int'(p1_v_q) + int'(p2_v_q)) < FIFO_DEPTH;
    head       = fifo_mem_q[rd_ptr_q];
    head_valid = (fifo_cnt_q != '0);
    pop        = head_valid && out_ready && !flush;
    push       = p2_v_q && !flush;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (row_count == 3'd0 || start_sum > 4'(NUM_ROWS)) begin
            err_d = 1'b1;
          end else begin
            // The first read goes out on the accepting edge itself.
            state_d    = S_RUN;
            busy_d     = 1'b1;
            mem_addr_d = ADDR_W'({row_base, {COL_W{1'b0}}});
            row_d      = row_base;
            col_d      = COL_W'(1);
            last_row_d = row_base + row_count - 3'd1;
            p1_v_d     = 1'b1;
            p1_last_d  = 1'b0;
            p1_flast_d = 1'b0;
            p1_row_d   = row_base;
          end
        end
      end
      S_RUN: begin
        if (issue_ok) begin
          mem_addr_d = ADDR_W'({row_q, col_q});
          p1_v_d     = 1'b1;
          p1_last_d  = col_last;
          p1_flast_d = col_last && (row_q == last_row_q);
          p1_row_d   = row_q;
          col_d      = col_q + 1'b1;
          if (col_last) row_d = row_q + 3'd1;
          if (col_last && (row_q == last_row_q)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head[DATA_W]) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      mem_addr_d = mem_addr_q;
      p1_v_d     = 1'b0;
      p2_v_d     = 1'b0;
    end

    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (push) begin
        fifo_mem_d[wr_ptr_q] = {p2_row_q, p2_last_q, p2_flast_q, mem_data};
        wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      last_row_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      p1_v_q     <= 1'b0;
      p1_last_q  <= 1'b0;
      p1_flast_q <= 1'b0;
      p1_row_q   <= '0;
      p2_v_q     <= 1'b0;
      p2_last_q  <= 1'b0;
      p2_flast_q <= 1'b0;
      p2_row_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      last_row_q <= last_row_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      p1_v_q     <= p1_v_d;
      p1_last_q  <= p1_last_d;
      p1_flast_q <= p1_flast_d;
      p1_row_q   <= p1_row_d;
      p2_v_q     <= p2_v_d;
      p2_last_q  <= p2_last_d;
      p2_flast_q <= p2_flast_d;
      p2_row_q   <= p2_row_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= fifo_mem_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mem_addr       = mem_addr_q;
  assign dbg_state      = state_q;
  assign out_valid      = head_valid;
  // Head fields read as zero while the FIFO is empty.
  assign out_data       = head_valid ? head[DATA_W-1:0] : '0;
  assign out_frame_last = head_valid && head[DATA_W];
  assign out_last       = head_valid && head[DATA_W+1];
  assign out_row        = head_valid ? head[ENT_W-1 -: 3] : 3'd0;

endmodule

// File: doc/dmem_read_sequencer.md
Name: dmem_read_sequencer

Overview:
Controller that sequences row-wise reads of the 112-entry x 9-bit data memory (7 rows x 16 entries) in the binary MLP. It is started with a row window and generates the memory read addresses. It absorbs the memory's fixed registered read latency and streams the returned words to a downstream consumer over a valid/ready interface. A 4-entry output FIFO sustains one word per cycle and gives lossless backpressure.

Parameters:
DATA_W, 9, memory word width
ADDR_W, 7, memory address width
ROW_LEN, 16, words per row (power of two)
NUM_ROWS, 7, rows in memory
FIFO_DEPTH, 4, output buffer entries (must be >= read pipeline depth 2 + 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE
row_base  in  3  first row to read (0..6)
row_count  in  3  number of rows to read (1..7)
abort  in  1  synchronous flush of any run in progress
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse after last beat handshakes
err  out  1  one-cycle pulse on rejected start
mem_addr  out  ADDR_W  registered address driven to data memory
mem_data  in  DATA_W  memory read data; valid 1 edge after mem_addr is sampled
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts when high with out_valid
out_data  out  DATA_W  FIFO head word
out_last  out  1  head word is the last word of a row (col 15)
out_frame_last  out  1  head word is the last word of the whole run
out_row  out  3  absolute row index of the head word

Behaviour:
- Reset (rst=0, async): state IDLE; mem_addr=0; busy=0; done=0; err=0; out_valid=0; out_data=0; out_last=0; out_frame_last=0; out_row=0; FIFO and in-flight pipeline cleared.
- Reset asserted mid-run: everything returns to reset values immediately. No done pulse. The run is lost.
- States: IDLE, RUN, DRAIN.
- IDLE + start with row_count=0 or row_base+row_count>7: err=1 for one cycle and the block stays in IDLE.
- IDLE + legal start: at the accepting edge, go to RUN, set busy=1, issue the first read with mem_addr=row_base*16, and load the issue counter.
- RUN issue rule: a read is issued on an edge only if fifo_count + inflight < FIFO_DEPTH, where inflight counts reads in the 2-stage pipeline. An issue sets mem_addr=row*16+col and then increments col; on col wrap from 15 to 0, row increments. When no read is issued, mem_addr holds its value.
- Read pipeline: issue at edge k; memory samples at edge k+1; mem_data is written into the FIFO at edge k+2, together with the last, frame_last and row tags carried down the pipeline. First out_valid appears 2 cycles after start is accepted.
- RUN -> DRAIN after the final read (row_base+row_count-1, col 15) is issued.
- DRAIN -> IDLE on the handshake of the frame_last word. done=1 in the following cycle, and busy falls with done.
- Throughput: 1 word per cycle with out_ready held high. Total beats = row_count*16.
- Backpressure: out_valid and the head word stay stable while out_ready=0. No word is lost or duplicated. The FIFO never overflows; issue stalls instead.
- Simultaneous FIFO push and pop on one edge: count is unchanged.
- abort (RUN or DRAIN): at the next edge, go to IDLE, flush FIFO and pipeline, out_valid=0, busy=0, no done. abort in IDLE has no effect. abort wins over start in the same cycle.
- start while busy is ignored, with no err.
- Address range is always 0..111. The sequencer never generates an address of 112 or above.

Test Plan:
1. Reset release, start base=0 count=1, out_ready=1 -> mem_addr 0..15 on consecutive cycles. 16 beats with data pattern 1,1,0,0 repeating. out_last only on beat 16. done 1 cycle after beat 16; busy low afterwards.
2. start base=0 count=7, out_ready=1 -> 112 contiguous beats. mem_addr ends at 111. out_row steps 0..6. out_frame_last only on beat 112.
3. base=2 count=2, out_ready toggling 1,0,0,1 pseudo-randomly -> exactly 32 beats, from addresses 32..63 in order. FIFO count never exceeds 4. Head is stable during stalls.
4. start base=5 count=3, and separately count=0 -> err pulse for 1 cycle; busy stays 0; mem_addr unchanged.
5. abort at beat 10 of a 3-row run -> out_valid=0 next cycle, no done. A new start base=1 count=1 then delivers addresses 16..31 cleanly.
6. rst pulled low asynchronously mid-RUN -> all outputs at reset values without waiting for a clock edge. A subsequent start works normally.
